// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, host loader) arbiter for one single-port
// synchronous RAM with 1-cycle read latency.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking; when
// it is undefined, the CPU always wins simultaneous requests.
//
// Request/response protocol (both requesters):
//   A requester raises req with we/addr/wdata valid. The arbiter samples the
//   inputs only at a clock edge where it is idle. The winner's gnt is high for
//   exactly one cycle (ACCESS), one cycle after that capture edge. Its done is
//   high for exactly one cycle (RESP), three cycles after capture. On reads,
//   rdata is valid with done and holds until that requester's next read
//   completes. The requester may drop or change its inputs after the capture
//   edge without affecting the access in flight. A req still high once the
//   arbiter is back in IDLE starts a new access. A losing requester gets no gnt
//   and simply stays pending.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  // CPU side
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  // Host (program loader) side
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_done,
  output logic [DW-1:0] host_rdata,
  // RAM side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // Status / debug
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  state_t        r_state;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_cpu_gnt;
  logic          r_host_gnt;
  logic          r_cpu_done;
  logic          r_host_done;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_host_rdata;
  logic          r_busy;

  logic          w_any_req;
  logic          w_winner;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

`ifdef MEM_ARB_RR_EN
  // Owner of the most recent capture; resets to host so the CPU wins the first tie.
  logic r_last_owner;

  // Remember who was served last so a tie goes to the other requester.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last_owner <= OWN_HOST;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_owner <= w_winner;
    end
  end
`endif

  // Pick the winner among the current requests and mux its access fields.
  always_comb begin
    w_any_req = cpu_req | host_req;
`ifdef MEM_ARB_RR_EN
    if (cpu_req && host_req) begin
      w_winner = (r_last_owner == OWN_HOST) ? OWN_CPU : OWN_HOST;
    end else begin
      w_winner = cpu_req ? OWN_CPU : OWN_HOST;
    end
`else
    w_winner = cpu_req ? OWN_CPU : OWN_HOST;
`endif
    if (w_winner == OWN_CPU) begin
      w_sel_we    = cpu_we;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
    end else begin
      w_sel_we    = host_we;
      w_sel_addr  = host_addr;
      w_sel_wdata = host_wdata;
    end
  end

  // Access sequencer: IDLE capture, ACCESS drives the RAM, WAIT absorbs the
  // read latency and captures read data, RESP signals completion.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_host_gnt   <= 1'b0;
      r_cpu_done   <= 1'b0;
      r_host_done  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_ACCESS;
            r_owner    <= w_winner;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_sel_we;
            r_cpu_gnt  <= (w_winner == OWN_CPU);
            r_host_gnt <= (w_winner == OWN_HOST);
            r_busy     <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_state    <= S_WAIT;
          r_mem_en   <= 1'b0;
          r_mem_we   <= 1'b0;
          r_cpu_gnt  <= 1'b0;
          r_host_gnt <= 1'b0;
        end
        S_WAIT: begin
          r_state <= S_RESP;
          if (!r_we) begin
            if (r_owner == OWN_CPU) begin
              r_cpu_rdata <= mem_rdata;
            end else begin
              r_host_rdata <= mem_rdata;
            end
          end
          r_cpu_done  <= (r_owner == OWN_CPU);
          r_host_done <= (r_owner == OWN_HOST);
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_cpu_done  <= 1'b0;
          r_host_done <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign cpu_done   = r_cpu_done;
  assign cpu_rdata  = r_cpu_rdata;
  assign host_gnt   = r_host_gnt;
  assign host_done  = r_host_done;
  assign host_rdata = r_host_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural RAM,
// directed scenarios and a randomized run against a reference model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_done;
  logic [15:0] cpu_rdata;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_gnt, host_done;
  logic [15:0] host_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Expected grant owners (0 = CPU, 1 = host) for the contention scenario.
  logic [0:0] exp_q[$];

  // Observations of the four cycles following a capture edge.
  logic        o_gc[4], o_gh[4], o_dc[4], o_dh[4], o_en[4], o_we[4], o_busy[4];
  logic [7:0]  o_addr[4];
  logic [15:0] o_wd[4], o_rc[4], o_rh[4];

  mem_arbiter #(.AW(8), .DW(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_done(host_done), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and behavioural single-port RAM with 1-cycle read latency.
  always #5 clock = ~clock;

  logic [15:0] ram [256];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: hold reset for two rising edges; returns on a falling edge.
  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    cpu_req = 1'b0; host_req = 1'b0; cpu_we = 1'b0; host_we = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Driver: must be called on a falling edge while idle. Presents one request
  // set, lets it be captured, then drops the requests and scrambles the inputs
  // during the grant cycle, recording the four following cycles.
  task automatic issue(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                       input logic [15:0] c_wd, input logic h_req, input logic h_we,
                       input logic [7:0] h_addr, input logic [15:0] h_wd);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wd;
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      o_gc[i] = cpu_gnt;   o_gh[i] = host_gnt;  o_dc[i] = cpu_done; o_dh[i] = host_done;
      o_en[i] = mem_en;    o_we[i] = mem_we;    o_busy[i] = busy;   o_addr[i] = mem_addr;
      o_wd[i] = mem_wdata; o_rc[i] = cpu_rdata; o_rh[i] = host_rdata;
      if (i == 0) begin
        cpu_req = 1'b0; host_req = 1'b0; cpu_addr = 8'h77; host_addr = 8'h77;
        cpu_we = ~cpu_we; host_we = ~host_we;
        cpu_wdata = 16'($urandom); host_wdata = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0b exp=0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
    checks++; if ({cpu_gnt, host_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {cpu_gnt, host_gnt}); end
    checks++; if ({cpu_done, host_done} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {cpu_done, host_done}); end
    checks++; if (cpu_rdata !== 16'h0) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=0000", cpu_rdata); end
    checks++; if (host_rdata !== 16'h0) begin failures++; $display("FAIL reset_host_rdata got=%h exp=0000", host_rdata); end
    checks++; if (mem_addr !== 8'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({busy, mem_en, cpu_gnt, host_gnt, cpu_done, host_done} !== 6'b0) begin
        failures++;
        $display("FAIL idle_quiet cycle=%0d got=%b exp=000000", i,
                 {busy, mem_en, cpu_gnt, host_gnt, cpu_done, host_done});
      end
    end
  endtask

  task automatic test_write_read();
    issue(1'b1, 1'b1, 8'h05, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0);
    checks++; if ({o_gc[0], o_gc[1], o_gc[2], o_gc[3]} !== 4'b1000) begin failures++; $display("FAIL wr_cpu_gnt got=%b exp=1000", {o_gc[0], o_gc[1], o_gc[2], o_gc[3]}); end
    checks++; if ({o_gh[0], o_gh[1], o_gh[2], o_gh[3]} !== 4'b0000) begin failures++; $display("FAIL wr_host_gnt got=%b exp=0000", {o_gh[0], o_gh[1], o_gh[2], o_gh[3]}); end
    checks++; if ({o_en[0], o_en[1], o_en[2], o_en[3]} !== 4'b1000) begin failures++; $display("FAIL wr_mem_en got=%b exp=1000", {o_en[0], o_en[1], o_en[2], o_en[3]}); end
    checks++; if ({o_we[0], o_we[1], o_we[2], o_we[3]} !== 4'b1000) begin failures++; $display("FAIL wr_mem_we got=%b exp=1000", {o_we[0], o_we[1], o_we[2], o_we[3]}); end
    checks++; if ({o_addr[0], o_wd[0]} !== {8'h05, 16'h1234}) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=05/1234", o_addr[0], o_wd[0]); end
    checks++; if ({o_dc[0], o_dc[1], o_dc[2], o_dc[3]} !== 4'b0010) begin failures++; $display("FAIL wr_cpu_done got=%b exp=0010", {o_dc[0], o_dc[1], o_dc[2], o_dc[3]}); end
    checks++; if ({o_busy[0], o_busy[1], o_busy[2], o_busy[3]} !== 4'b1110) begin failures++; $display("FAIL wr_busy got=%b exp=1110", {o_busy[0], o_busy[1], o_busy[2], o_busy[3]}); end
    checks++; if (o_rc[2] !== 16'h0) begin failures++; $display("FAIL wr_rdata_untouched got=%h exp=0000", o_rc[2]); end
    issue(1'b1, 1'b0, 8'h05, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    checks++; if ({o_en[0], o_we[0]} !== 2'b10) begin failures++; $display("FAIL rd_en_we got=%b exp=10", {o_en[0], o_we[0]}); end
    checks++; if ({o_dc[0], o_dc[1], o_dc[2], o_dc[3]} !== 4'b0010) begin failures++; $display("FAIL rd_cpu_done got=%b exp=0010", {o_dc[0], o_dc[1], o_dc[2], o_dc[3]}); end
    checks++; if (o_rc[2] !== 16'h1234) begin failures++; $display("FAIL rd_cpu_rdata got=%h exp=1234", o_rc[2]); end
    checks++; if (o_rh[2] !== 16'h0) begin failures++; $display("FAIL rd_host_rdata got=%h exp=0000", o_rh[2]); end
  endtask

  task automatic test_host_then_cpu();
    issue(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
    checks++; if ({o_gc[0], o_gh[0]} !== 2'b01) begin failures++; $display("FAIL hw_gnt got=%b exp=01", {o_gc[0], o_gh[0]}); end
    checks++; if ({o_dc[2], o_dh[2]} !== 2'b01) begin failures++; $display("FAIL hw_done got=%b exp=01", {o_dc[2], o_dh[2]}); end
    checks++; if (o_rh[2] !== 16'h0) begin failures++; $display("FAIL hw_host_rdata got=%h exp=0000", o_rh[2]); end
    issue(1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    checks++; if (o_rc[2] !== 16'hBEEF) begin failures++; $display("FAIL cr_cpu_rdata got=%h exp=beef", o_rc[2]); end
    checks++; if (o_rh[3] !== 16'h0) begin failures++; $display("FAIL cr_host_rdata got=%h exp=0000", o_rh[3]); end
  endtask

  task automatic test_req_drop();
    issue(1'b1, 1'b0, 8'h05, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    checks++; if ({o_addr[0], o_addr[1]} !== {8'h05, 8'h05}) begin failures++; $display("FAIL drop_addr got=%h/%h exp=05/05", o_addr[0], o_addr[1]); end
    checks++; if ({o_we[0], o_we[1]} !== 2'b00) begin failures++; $display("FAIL drop_we got=%b exp=00", {o_we[0], o_we[1]}); end
    checks++; if ({o_dc[0], o_dc[1], o_dc[2], o_dc[3]} !== 4'b0010) begin failures++; $display("FAIL drop_done got=%b exp=0010", {o_dc[0], o_dc[1], o_dc[2], o_dc[3]}); end
    checks++; if (o_rc[2] !== 16'h1234) begin failures++; $display("FAIL drop_rdata got=%h exp=1234", o_rc[2]); end
    repeat (2) @(negedge clock);
    checks++; if ({busy, cpu_done, mem_en} !== 3'b000) begin failures++; $display("FAIL drop_no_repeat got=%b exp=000", {busy, cpu_done, mem_en}); end
  endtask

  task automatic test_contention();
    logic [0:0] exp_owner;
    logic [0:0] got_owner;
    apply_reset();
    exp_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(RR ? 1'b1 : 1'b0);
    exp_q.push_back(1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      exp_owner = exp_q.pop_front();
      got_owner = host_gnt;
      checks++;
      if ((cpu_gnt ^ host_gnt) !== 1'b1 || got_owner !== exp_owner) begin
        failures++;
        $display("FAIL tie_grant n=%0d got cpu_gnt=%0b host_gnt=%0b exp_owner=%0d", i, cpu_gnt, host_gnt, exp_owner);
      end
      for (int j = 0; j < 3; j++) begin
        @(negedge clock);
        checks++;
        if ({cpu_gnt, host_gnt} !== 2'b00) begin failures++; $display("FAIL tie_gnt_quiet n=%0d j=%0d got=%b exp=00", i, j, {cpu_gnt, host_gnt}); end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    checks++; if (host_rdata !== (RR ? 16'hBEEF : 16'h0)) begin failures++; $display("FAIL tie_host_rdata got=%h exp=%h", host_rdata, RR ? 16'hBEEF : 16'h0); end
    checks++; if (cpu_rdata !== 16'h1234) begin failures++; $display("FAIL tie_cpu_rdata got=%h exp=1234", cpu_rdata); end
    @(negedge clock);
  endtask

  task automatic test_reset_abort();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    @(posedge clock);
    @(negedge clock);
    cpu_req = 1'b0;
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL abort_access_en got=%0b exp=1", mem_en); end
    @(negedge clock);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_wait_busy got=%0b exp=1", busy); end
    reset_n = 1'b0;
    @(negedge clock);
    checks++; if ({cpu_done, busy, mem_en} !== 3'b000) begin failures++; $display("FAIL abort_outputs got=%b exp=000", {cpu_done, busy, mem_en}); end
    checks++; if (cpu_rdata !== 16'h0) begin failures++; $display("FAIL abort_rdata got=%h exp=0000", cpu_rdata); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({cpu_done, busy, cpu_rdata} !== 18'h0) begin failures++; $display("FAIL abort_after i=%0d done=%0b busy=%0b rdata=%h exp=0/0/0000", i, cpu_done, busy, cpu_rdata); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [logic [7:0]];
    logic [15:0] exp_rc, exp_rh;
    logic        last_owner, winner, cr, hr, cw, hw, w_we;
    logic [7:0]  ca, ha, w_addr;
    logic [15:0] cd, hd, w_data;
    logic [1:0]  sel;
    apply_reset();
    ref_mem[8'h05] = 16'h1234;
    ref_mem[8'h10] = 16'hBEEF;
    exp_rc = 16'h0; exp_rh = 16'h0; last_owner = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sel = 2'($urandom_range(1, 3));
      cr = sel[0]; hr = sel[1];
      cw = 1'($urandom_range(0, 1)); hw = 1'($urandom_range(0, 1));
      ca = 8'($urandom_range(0, 7)) + 8'h04; ha = 8'($urandom_range(0, 7)) + 8'h04;
      cd = 16'($urandom); hd = 16'($urandom);
      if (!cw && !ref_mem.exists(ca)) cw = 1'b1;
      if (!hw && !ref_mem.exists(ha)) hw = 1'b1;
      if (cr && hr) winner = RR ? ~last_owner : 1'b0;
      else          winner = hr & ~cr;
      last_owner = winner;
      w_we = winner ? hw : cw; w_addr = winner ? ha : ca; w_data = winner ? hd : cd;
      issue(cr, cw, ca, cd, hr, hw, ha, hd);
      if (w_we) ref_mem[w_addr] = w_data;
      else if (winner) exp_rh = ref_mem[w_addr];
      else exp_rc = ref_mem[w_addr];
      checks++; if ({o_gc[0], o_gh[0]} !== {~winner, winner}) begin failures++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, {o_gc[0], o_gh[0]}, {~winner, winner}); end
      checks++; if ({o_en[0], o_we[0], o_addr[0]} !== {1'b1, w_we, w_addr}) begin failures++; $display("FAIL rnd_mem n=%0d got en=%0b we=%0b addr=%h exp 1/%0b/%h", n, o_en[0], o_we[0], o_addr[0], w_we, w_addr); end
      checks++; if ({o_dc[1], o_dh[1], o_dc[2], o_dh[2], o_dc[3], o_dh[3]} !== {2'b00, ~winner, winner, 2'b00}) begin failures++; $display("FAIL rnd_done n=%0d got=%b exp=00%b%b00", n, {o_dc[1], o_dh[1], o_dc[2], o_dh[2], o_dc[3], o_dh[3]}, ~winner, winner); end
      checks++; if ({o_rc[2], o_rh[2]} !== {exp_rc, exp_rh}) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h/%h exp=%h/%h", n, o_rc[2], o_rh[2], exp_rc, exp_rh); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write_read();
    test_host_then_cpu();
    test_req_drop();
    test_contention();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width in bits.
REQ-002 SHALL have parameter DW, default 16, memory data width in bits.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have CPU ports cpu_req in 1, cpu_we in 1, cpu_addr in AW, cpu_wdata in DW: access request, write enable, address and write data from the processor core.
REQ-006 SHALL have CPU ports cpu_gnt out 1, cpu_done out 1, cpu_rdata out DW: request captured, access complete, read data.
REQ-007 SHALL have host ports host_req, host_we, host_addr, host_wdata (inputs) and host_gnt, host_done, host_rdata (outputs), with the same widths and meanings as the CPU set, for the program loader.
REQ-008 SHALL have RAM ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_rdata in DW, driving one single-port synchronous RAM with 1-cycle read latency.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP, advancing unconditionally ACCESS->WAIT->RESP->IDLE.
REQ-011 In IDLE with any req high, SHALL choose one winner (REQ-020/021), latch its we/addr/wdata and the owner id, and go to ACCESS on the same edge; with no req, SHALL stay in IDLE.
REQ-012 SHALL assert the winner's gnt for exactly the ACCESS cycle; the loser's gnt SHALL stay low.
REQ-013 In ACCESS, SHALL drive mem_en=1, mem_we=latched we, mem_addr/mem_wdata from the latches; in all other states mem_en=0 and mem_we=0.
REQ-014 In WAIT, on a read, SHALL capture mem_rdata into the owner's rdata register; on a write, SHALL leave both rdata registers unchanged.
REQ-015 SHALL assert the owner's done for exactly the RESP cycle; owner's rdata SHALL hold its value until that requester's next read completes.
REQ-016 Latency: req sampled in IDLE at edge k -> gnt high cycle k+1 -> done high cycle k+3; next arbitration no earlier than cycle k+4.
REQ-017 Requester inputs SHALL be sampled only at the IDLE capture edge; later changes (including dropping req) SHALL NOT affect the access in flight.
REQ-018 A req still high in the IDLE cycle after RESP SHALL be treated as a new access.
REQ-019 A requester losing arbitration SHALL remain pending with no gnt until it wins.

Configuration
REQ-020 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL go to the requester not served last (round-robin via a last_owner register updated at each capture edge).
REQ-021 Without MEM_ARB_RR_EN, simultaneous requests SHALL always go to the CPU (fixed priority), and no last_owner register SHALL exist.

Reset
REQ-022 While reset_n=0 at a rising edge, SHALL go to IDLE and clear gnt, done, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, host_rdata, busy and latches to 0; last_owner (if present) SHALL reset to host so the CPU wins the first tie.
REQ-023 Reset during ACCESS, WAIT or RESP SHALL abort the access: no done pulse, no rdata update, mem_en low from the following cycle.
REQ-024 After reset_n returns high, the first capture SHALL occur at the first edge where reset_n=1 and any req=1.

Verification
REQ-025 CPU write addr 0x05 data 0x1234, then CPU read addr 0x05 -> write: mem_we=1 in ACCESS only; read: cpu_done cycle k+3, cpu_rdata=0x1234.
REQ-026 Host writes 0xBEEF to 0x10, CPU reads 0x10 -> cpu_rdata=0xBEEF, host_rdata unchanged at 0x0000.
REQ-027 cpu_req and host_req both high for 3 accesses -> with MEM_ARB_RR_EN: grants CPU, host, CPU; without: CPU, CPU, CPU.
REQ-028 Reset asserted in WAIT of a read of 0x05 (RAM holds 0x1234) -> no cpu_done, cpu_rdata=0x0000, busy=0, mem_en=0 next cycle.
REQ-029 CPU drops req and changes cpu_addr to 0x77 in ACCESS cycle of a read at 0x05 -> access completes at 0x05, cpu_done pulses once.
REQ-030 No req for 10 cycles after reset -> busy, mem_en, all gnt/done stay 0.
